// File: rtl/dump_stage.sv
// dump_stage: output end of the SHAKE core; takes rate-wide squeezed blocks and streams W-bit words.
// Optional macro DUMP_LAST_WORD_MASK_EN zeroes the bits past the requested length in the final word.
module dump_stage #(
    parameter int W      = 64,
    parameter int RATE   = 1344,
    parameter int SIZE_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE_W-1:0] output_size,
    input  logic [1:0]        operation_mode,
    input  logic [RATE-1:0]   output_buffer_in,
    input  logic              output_buffer_ready,
    output logic              output_buffer_ready_wr,
    output logic              last_block_out_wr,
    output logic [W-1:0]      data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              last_out,
    output logic              ready_out,
    output logic              done
);
    localparam int WPB128 = RATE / W;
    localparam int WPB256 = 1088 / W;
    localparam int CNT_W  = $clog2(WPB128 + 1);

    localparam logic [CNT_W-1:0]  WPB128_C = CNT_W'(WPB128);
    localparam logic [CNT_W-1:0]  WPB256_C = CNT_W'(WPB256);
    localparam logic [SIZE_W-1:0] BLK128_C = SIZE_W'(WPB128 * W);
    localparam logic [SIZE_W-1:0] BLK256_C = SIZE_W'(WPB256 * W);
    localparam logic [SIZE_W-1:0] W_C      = SIZE_W'(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BLOCK,
        S_STREAM,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [RATE-1:0]    shreg_q, shreg_d;
    logic [SIZE_W-1:0]  remaining_q, remaining_d;
    logic               mode256_q, mode256_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               ready_wr_q, ready_wr_d;
    logic               last_blk_q, last_blk_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   words_per_block;
    logic [SIZE_W-1:0]  block_bits;
    logic [SIZE_W-1:0]  xfer_bits;
    logic [SIZE_W-1:0]  rem_after;
    logic [CNT_W-1:0]   word_cnt_inc;
    logic [W-1:0]       top_word;
    logic [W-1:0]       out_word;

    assign words_per_block = mode256_q ? WPB256_C : WPB128_C;
    assign block_bits      = mode256_q ? BLK256_C : BLK128_C;
    // Saturating decrement: the final word may carry fewer than W requested bits.
    assign xfer_bits       = (remaining_q < W_C) ? remaining_q : W_C;
    assign rem_after       = remaining_q - xfer_bits;
    assign word_cnt_inc    = word_cnt_q + 1'b1;
    assign top_word        = shreg_q[RATE-1 -: W];

`ifdef DUMP_LAST_WORD_MASK_EN
    assign out_word = (remaining_q < W_C) ? (top_word & ~({W{1'b1}} >> remaining_q)) : top_word;
`else
    assign out_word = top_word;
`endif

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        remaining_d = remaining_q;
        mode256_d   = mode256_q;
        word_cnt_d  = word_cnt_q;
        ready_wr_d  = 1'b0;
        last_blk_d  = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = output_size;
                    mode256_d   = (operation_mode == 2'd1);
                    state_d     = (output_size == '0) ? S_DONE : S_WAIT_BLOCK;
                end
            end
            S_WAIT_BLOCK: begin
                if (output_buffer_ready) begin
                    shreg_d    = output_buffer_in;
                    word_cnt_d = '0;
                    ready_wr_d = 1'b1;
                    last_blk_d = (remaining_q <= block_bits);
                    state_d    = S_STREAM;
                end
            end
            S_STREAM: begin
                if (ready_in) begin
                    shreg_d     = shreg_q << W;
                    word_cnt_d  = word_cnt_inc;
                    remaining_d = rem_after;
                    if (rem_after == '0) begin
                        state_d = S_DONE;
                    end else if (word_cnt_inc == words_per_block) begin
                        state_d = S_WAIT_BLOCK;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            remaining_q <= '0;
            mode256_q   <= 1'b0;
            word_cnt_q  <= '0;
            ready_wr_q  <= 1'b0;
            last_blk_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            remaining_q <= remaining_d;
            mode256_q   <= mode256_d;
            word_cnt_q  <= word_cnt_d;
            ready_wr_q  <= ready_wr_d;
            last_blk_q  <= last_blk_d;
            done_q      <= done_d;
        end
    end

    // Stream outputs are decoded from registered state only, so they hold while stalled.
    assign valid_out              = (state_q == S_STREAM);
    assign data_out               = valid_out ? out_word : '0;
    assign last_out               = valid_out && (remaining_q <= W_C);
    assign ready_out              = (state_q == S_IDLE);
    assign output_buffer_ready_wr = ready_wr_q;
    assign last_block_out_wr      = last_blk_q;
    assign done                   = done_q;

endmodule

// File: doc/dump_stage.md
Name: dump_stage

Overview:
- Output end of the SHAKE core, mirroring the load stage.
- Accepts full rate-wide squeezed blocks from the permute stage through the same ready/ready_wr flag handshake the load stage uses toward it.
- Serializes each block into W-bit words on a valid/ready stream until the requested output length is delivered.
- Tells the permute stage when the current block is the last one needed.

Parameters:
- W, 64, output word width in bits.
- RATE, 1344, width of output_buffer_in (SHAKE128 rate; largest supported).
- SIZE_W, 32, width of the output length field, in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; latch output_size and operation_mode, begin a request.
- output_size  in  SIZE_W  requested output length in bits.
- operation_mode  in  2  0 = SHAKE128 (21 words/block), 1 = SHAKE256 (17 words/block); 2/3 treated as 0.
- output_buffer_in  in  RATE  squeezed block; word 0 = bits [RATE-1 -: W].
- output_buffer_ready  in  1  permute stage has a block waiting.
- output_buffer_ready_wr  out  1  one-cycle pulse: block consumed, producer clears its flag.
- last_block_out_wr  out  1  pulses with output_buffer_ready_wr when the consumed block completes the request.
- data_out  out  W  output word.
- valid_out  out  1  data_out valid.
- ready_in  in  1  downstream accepts.
- last_out  out  1  high with valid_out on the final word.
- ready_out  out  1  high in IDLE; start is honoured only then.
- done  out  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (rst low, async): state IDLE. The shift register, data_out, valid_out, last_out, output_buffer_ready_wr, last_block_out_wr and done are 0. The remaining-bit counter is 0 and ready_out = 1.
- IDLE: on start, latch remaining = output_size and words_per_block per mode.
  - If output_size = 0, go to DONE; no block is consumed.
  - Otherwise go to WAIT_BLOCK. ready_out = 0 outside IDLE.
- WAIT_BLOCK: when output_buffer_ready = 1:
  - Load the shift register from output_buffer_in and set word_cnt = 0.
  - Pulse output_buffer_ready_wr for exactly one cycle.
  - Pulse last_block_out_wr in the same cycle if remaining <= words_per_block*W.
  - Go to STREAM. First valid_out appears the cycle after the load (latency 1).
- STREAM: data_out = current top word and valid_out = 1.
  - While valid_out and !ready_in, data_out/valid_out/last_out hold stable.
  - On transfer (valid_out & ready_in): shift by W, word_cnt+1, remaining -= min(remaining, W).
  - After the transfer:
    - If remaining reaches 0: valid_out = 0, go to DONE.
    - Else if word_cnt = words_per_block: go to WAIT_BLOCK; valid_out drops, there are no bubble-free block joins.
    - Else present the next word the following cycle.
- last_out = 1 iff remaining <= W while the word is presented.
- Last-word masking, when remaining < W: keep the top `remaining` bits and zero the lower bits (see optional feature).
- DONE: pulse done for one cycle, return to IDLE with ready_out = 1.
- start outside IDLE is ignored.
- The remaining counter saturates at 0 and never wraps. Arithmetic is SIZE_W unsigned.
- A block arriving while in STREAM/IDLE is not consumed; output_buffer_ready_wr is never asserted outside WAIT_BLOCK.
- Reset mid-stream aborts immediately: all outputs return to reset values, the partial block is dropped, and no done pulse is issued.

Optional Feature:
- Macro: DUMP_LAST_WORD_MASK_EN.
- Defined: the final partial word has bits below the requested length zeroed, as described in Behaviour.
- Undefined: the final word is emitted unmasked, i.e. the full W bits of the block word. Length accounting, last_out and done are unchanged.

Test Plan:
- SHAKE128, output_size=256, ready_in=1:
  - Exactly one output_buffer_ready_wr, with last_block_out_wr=1.
  - 4 words equal to the top 4 block words; last_out on word 4.
  - done 1 cycle after word 4; ready_out returns high.
- SHAKE128, output_size=2000:
  - Two blocks consumed; last_block_out_wr only on the second.
  - 32 words (21+11); valid_out gaps at the block boundary.
  - Word 32 keeps top 16 bits, low 48 bits zero (mask on); unmasked with DUMP_LAST_WORD_MASK_EN undefined.
- SHAKE256, output_size=2176: 34 words, 17 per block; two output_buffer_ready_wr pulses; the second carries last_block_out_wr.
- Backpressure: output_size=256, ready_in toggled 1-0-0-1 pseudo-randomly:
  - data_out and last_out stable while stalled.
  - Exactly 4 transfers, no duplicated or skipped words.
- output_size=0: start leads to a done pulse two cycles later; no output_buffer_ready_wr, no valid_out. A start pulse while busy is ignored.
- Reset mid-stream: rst low after word 5 of 21.
  - All outputs at reset values asynchronously; ready_out=1.
  - A new request with output_size=64 then produces a single correct word.
